// File: rtl/cardinal_nic_q.sv
// cardinal_nic_q: DEPTH-entry injection/ejection queues between a cmp16 node and its mesh router port.
// Define CARDINAL_NIC_POLARITY_GATE_EN to inject only in the head packet's virtual-channel phase.
module cardinal_nic_q #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 4,
    parameter int VC_BIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nicEn,
    input  logic              nicWrEn,
    input  logic [0:1]        addr,
    input  logic [0:DATA_W-1] d_in,
    output logic [0:DATA_W-1] d_out,
    input  logic              net_polarity,
    output logic              net_so,
    input  logic              net_ro,
    output logic [0:DATA_W-1] net_do,
    input  logic              net_si,
    output logic              net_ri,
    input  logic [0:DATA_W-1] net_di
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [0:DATA_W-1] oq_mem_q [DEPTH];
    logic [0:DATA_W-1] iq_mem_q [DEPTH];
    logic [AW-1:0] oq_rd_q, oq_rd_d, oq_wr_q, oq_wr_d;
    logic [AW-1:0] iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;
    logic [CW-1:0] oq_cnt_q, oq_cnt_d, iq_cnt_q, iq_cnt_d;
    logic          ovf_q, ovf_d;

    logic oq_full, oq_empty, iq_full, iq_empty;
    logic rd_en, wr_out, oq_push, oq_pop, iq_push, iq_pop;
    logic gate;
    logic [0:DATA_W-1] oq_head;

    assign oq_full  = (oq_cnt_q == FULL_CNT);
    assign oq_empty = (oq_cnt_q == '0);
    assign iq_full  = (iq_cnt_q == FULL_CNT);
    assign iq_empty = (iq_cnt_q == '0);
    assign oq_head  = oq_mem_q[oq_rd_q];

`ifdef CARDINAL_NIC_POLARITY_GATE_EN
    assign gate = (oq_head[VC_BIT] == net_polarity);
`else
    logic polarity_unused;
    assign polarity_unused = net_polarity;
    assign gate = 1'b1;
`endif

    always_comb begin
        rd_en   = reset & nicEn & ~nicWrEn;
        wr_out  = reset & nicEn & nicWrEn & (addr == 2'b10);
        oq_push = wr_out & ~oq_full;
        net_so  = reset & ~oq_empty & net_ro & gate;
        oq_pop  = net_so;
        net_ri  = reset & ~iq_full;
        iq_push = net_si & net_ri;
        iq_pop  = rd_en & (addr == 2'b00) & ~iq_empty;
        net_do  = reset ? oq_head : '0;
    end

    always_comb begin
        d_out = '0;
        if (rd_en) begin
            unique case (addr)
                2'b00: d_out = iq_empty ? '0 : iq_mem_q[iq_rd_q];
                2'b01: begin
                    d_out[DATA_W-1]           = ~iq_empty;
                    d_out[DATA_W-16:DATA_W-9] = 8'(iq_cnt_q);
                end
                2'b10: d_out = '0;
                2'b11: begin
                    d_out[DATA_W-1]           = oq_full;
                    d_out[DATA_W-16:DATA_W-9] = 8'(oq_cnt_q);
                    d_out[DATA_W-17]          = ovf_q;
                end
                default: d_out = '0;
            endcase
        end
    end

    always_comb begin
        oq_rd_d  = oq_rd_q + AW'(oq_pop);
        oq_wr_d  = oq_wr_q + AW'(oq_push);
        oq_cnt_d = oq_cnt_q + CW'(oq_push) - CW'(oq_pop);
        iq_rd_d  = iq_rd_q + AW'(iq_pop);
        iq_wr_d  = iq_wr_q + AW'(iq_push);
        iq_cnt_d = iq_cnt_q + CW'(iq_push) - CW'(iq_pop);
        ovf_d    = ovf_q;
        if (rd_en && addr == 2'b11) ovf_d = 1'b0;
        // A drop in the same edge as a status read still leaves ovf set
        if (wr_out && oq_full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            oq_rd_q  <= '0;
            oq_wr_q  <= '0;
            oq_cnt_q <= '0;
            iq_rd_q  <= '0;
            iq_wr_q  <= '0;
            iq_cnt_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            oq_rd_q  <= oq_rd_d;
            oq_wr_q  <= oq_wr_d;
            oq_cnt_q <= oq_cnt_d;
            iq_rd_q  <= iq_rd_d;
            iq_wr_q  <= iq_wr_d;
            iq_cnt_q <= iq_cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (oq_push) oq_mem_q[oq_wr_q] <= d_in;
        if (iq_push) iq_mem_q[iq_wr_q] <= net_di;
    end
endmodule

// File: doc/cardinal_nic_q.md
# cardinal_nic_q

Parametrised network interface controller that bridges one cmp16 processor node's memory-mapped NIC port to one local port of the cardinal mesh router. It replaces the single-entry NIC used in the current 16-node build with DEPTH-entry injection and ejection queues, occupancy-reporting status words, and sticky overflow detection. The cardinal_cmp top level instantiates it once per mesh node.

## Interface
- DATA_W, 64, packet and processor data width; bit 0 is MSB, big-endian [0:DATA_W-1].
- DEPTH, 4, entries per queue; a power of 2, 2..128.
- VC_BIT, 0, packet bit carrying the virtual-channel (even/odd) tag.

Ports, clock and reset first:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low. Sampled on the rising edge of clk; state clears while reset==0.
- nicEn  in  1  processor access strobe.
- nicWrEn  in  1  1 = write, 0 = read; valid only with nicEn.
- addr  in  [0:1]  00 = input data, 01 = input status, 10 = output data, 11 = output status.
- d_in  in  [0:DATA_W-1]  processor write data.
- d_out  out  [0:DATA_W-1]  processor read data.
- net_polarity  in  1  router even/odd cycle phase.
- net_so  out  1  injection valid to the router.
- net_ro  in  1  router local-input buffer has space.
- net_do  out  [0:DATA_W-1]  injection packet.
- net_si  in  1  ejection valid from the router.
- net_ri  out  1  NIC can accept an ejected packet.
- net_di  in  [0:DATA_W-1]  ejected packet.

## Operation
- Two circular FIFOs.
  - oq: processor to network.
  - iq: network to processor.
  - Each FIFO has DEPTH entries, rd/wr pointers and a count of clog2(DEPTH)+1 bits.
- Processor write, with nicEn=1, nicWrEn=1, addr=10:
  - If oq is not full, push d_in.
  - If oq is full, drop the word and set the sticky bit ovf.
  - A write to any other addr is ignored.
- Processor read, with nicEn=1, nicWrEn=0. d_out is combinational:
  - addr=00: d_out = iq head, or 0 if iq is empty. Pops iq on the edge if iq is not empty.
  - addr=01: d_out[DATA_W-1] = iq not-empty; d_out[DATA_W-16:DATA_W-9] = iq count, zero-extended; all other bits 0.
  - addr=10: d_out = 0.
  - addr=11: d_out[DATA_W-1] = oq full; d_out[DATA_W-16:DATA_W-9] = oq count; d_out[DATA_W-17] = ovf; all other bits 0. The read clears ovf on the edge.
  - d_out = 0 whenever nicEn=0.
- Injection:
  - net_do = oq head.
  - net_so = oq not empty AND net_ro AND gate, where gate is defined under Configuration.
  - oq pops on the edge where net_so=1.
- Ejection:
  - net_ri = iq not full.
  - iq pushes net_di on the edge where net_si AND net_ri.
  - Words arriving with net_si=1 while net_ri=0 are not captured; this is a router protocol violation.
- Ordering: both queues are strict FIFO.
- Pointer arithmetic: pointers wrap modulo DEPTH.

## Timing
- While reset==0:
  - pointers, counts and ovf are 0;
  - net_so=0, net_ri=0, d_out=0, net_do=0.
  - This overrides all other inputs.
  - The first edge with reset==1 is the first functional edge.
- Reset asserted mid-operation discards all queued words in the same edge and clears ovf.
- Latency:
  - A processor write at edge N can inject at edge N+1 at the earliest.
  - An ejected word captured at edge N is readable at addr 00 in cycle N+1.
- Simultaneous push and pop on one queue in one edge leaves count unchanged and keeps data intact. This holds at count = DEPTH-1 and at count = 1.
- Full and empty are evaluated on pre-edge state:
  - A write to a full oq is dropped even if an injection pops in the same edge.
  - A read of an empty iq returns 0 and does not pop, even if a push occurs in the same edge.
- An overflow drop and a status read of ovf in the same edge: the read returns the old ovf, and ovf ends at 1, because set wins.

## Configuration
- CARDINAL_NIC_POLARITY_GATE_EN
  - Defined: gate = (oq head[VC_BIT] == net_polarity), so a packet injects only in its virtual channel's phase. A head that is blocked on phase blocks the queue; there is no reordering.
  - Undefined: gate = 1. net_polarity is ignored and injection depends only on net_ro and oq occupancy.

## Test plan
- Reset: hold reset=0 for 3 cycles with net_si=1, nicEn=1, addr=01 -> net_ri=0, net_so=0, d_out=0. After release: net_ri=1 and a status read returns 0.
- Overflow (DEPTH=4, net_ro=0): write 0x11, 0x22, 0x33, 0x44, 0x55 -> the addr=11 read shows bit 63=1, count=4, ovf=1. A second read shows ovf=0. Raising net_ro then injects 0x11..0x44 in order; 0x55 never appears.
- Polarity gating (macro defined): oq holds two words with VC_BIT=1, net_ro=1, net_polarity toggling from 0 -> net_so=1 only in cycles with polarity=1, giving exactly 2 injections in the first 4 cycles. With the macro undefined: 2 injections in 2 consecutive cycles.
- Ejection read: push 0xA5 then 0x5A via net_si -> addr=01 read gives bit 63=1, count=2. addr=00 reads return 0xA5, then 0x5A, then 0 with no count change.
- Full/simultaneous: push 4 words with no reads -> net_ri=0 from the cycle after the 4th push. At count=3, a read at 00 in the same cycle as a push -> count stays 3 and order is preserved.
- Reset mid-operation: with 2 words in each queue and ovf=1, pulse reset=0 for 1 cycle -> both status words read 0 afterwards, net_so=0, net_ri=1.
